// File: rtl/xbar_slave_port_if.sv
// xbar_slave_port_if: master-, arbiter- and slave-side signal bundle of one crossbar slave port
interface xbar_slave_port_if #(
   parameter int AW = 32,
   parameter int DW = 64
);
   logic [15:0]      m_valid;
   logic [15:0]      m_wr;
   logic [16*AW-1:0] m_addr;
   logic [16*DW-1:0] m_wdata;
   logic [15:0]      m_ready;
   logic [15:0]      m_rvalid;
   logic [DW-1:0]    m_rdata;
   logic [15:0]      arb_request;
   logic [15:0]      arb_grant;
   logic             s_valid;
   logic             s_ready;
   logic             s_wr;
   logic [AW-1:0]    s_addr;
   logic [DW-1:0]    s_wdata;
   logic             s_rvalid;
   logic [DW-1:0]    s_rdata;
   logic             busy;
   modport slave (
      input  m_valid, m_wr, m_addr, m_wdata, arb_grant, s_ready, s_rvalid, s_rdata,
      output m_ready, m_rvalid, m_rdata, arb_request, s_valid, s_wr, s_addr, s_wdata, busy
   );
   modport master (
      output m_valid, m_wr, m_addr, m_wdata, arb_grant, s_ready, s_rvalid, s_rdata,
      input  m_ready, m_rvalid, m_rdata, arb_request, s_valid, s_wr, s_addr, s_wdata, busy
   );
endinterface

// File: rtl/xbar_slave_port.sv
// xbar_slave_port: per-slave crossbar front end running one arbitrated command/response at a time
module xbar_slave_port #(
   parameter int AW = 32,
   parameter int DW = 64
) (
   input logic               clk,
   input logic               rst_n,
   xbar_slave_port_if.slave  bus
);
   typedef enum logic [1:0] {IDLE, CMD, RESP} state_t;
   state_t        state_q, state_d;
   logic [15:0]   owner_q, owner_d;
   logic          s_valid_q, s_valid_d;
   logic          s_wr_q, s_wr_d;
   logic [AW-1:0] s_addr_q, s_addr_d;
   logic [DW-1:0] s_wdata_q, s_wdata_d;
   logic          busy_q, busy_d;
   logic          wr_sel;
   logic [AW-1:0] addr_sel;
   logic [DW-1:0] wdata_sel;
   logic          idle;
   logic          rsp;
   assign idle            = rst_n && state_q == IDLE;
   assign rsp             = state_q == RESP && bus.s_rvalid;
   assign bus.arb_request = idle ? bus.m_valid : '0;
   assign bus.m_ready     = idle ? bus.arb_grant : '0;
   assign bus.m_rvalid    = rsp ? owner_q : '0;
   assign bus.m_rdata     = rsp ? bus.s_rdata : '0;
   assign bus.s_valid     = s_valid_q;
   assign bus.s_wr        = s_wr_q;
   assign bus.s_addr      = s_addr_q;
   assign bus.s_wdata     = s_wdata_q;
   assign bus.busy        = busy_q;
   // one-hot grant selects the winning master's payload by AND-OR reduction
   always_comb begin
      wr_sel    = 1'b0;
      addr_sel  = '0;
      wdata_sel = '0;
      for (int i = 0; i < 16; i++) begin
         wr_sel    |= bus.m_wr[i] & bus.arb_grant[i];
         addr_sel  |= bus.m_addr[i*AW +: AW] & {AW{bus.arb_grant[i]}};
         wdata_sel |= bus.m_wdata[i*DW +: DW] & {DW{bus.arb_grant[i]}};
      end
   end
   // transaction sequencing: grant in IDLE, hold command until accepted, wait for response
   always_comb begin
      state_d   = state_q;
      owner_d   = owner_q;
      s_wr_d    = s_wr_q;
      s_addr_d  = s_addr_q;
      s_wdata_d = s_wdata_q;
      if (state_q == IDLE && |bus.arb_grant) begin
         state_d   = CMD;
         owner_d   = bus.arb_grant;
         s_wr_d    = wr_sel;
         s_addr_d  = addr_sel;
         s_wdata_d = wdata_sel;
      end else if (state_q == CMD && bus.s_ready) begin
         state_d = RESP;
      end else if (rsp) begin
         state_d = IDLE;
         owner_d = '0;
      end
      s_valid_d = state_d == CMD;
      busy_d    = state_d != IDLE;
   end
   // state and registered outputs; reset aborts any transaction silently
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         owner_q   <= '0;
         s_valid_q <= 1'b0;
         s_wr_q    <= 1'b0;
         s_addr_q  <= '0;
         s_wdata_q <= '0;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         owner_q   <= owner_d;
         s_valid_q <= s_valid_d;
         s_wr_q    <= s_wr_d;
         s_addr_q  <= s_addr_d;
         s_wdata_q <= s_wdata_d;
         busy_q    <= busy_d;
      end
   end
   a_grant_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(bus.arb_grant))
      else $error("arb_grant not one-hot: %h", bus.arb_grant);
   a_ready_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(bus.m_ready))
      else $error("m_ready not one-hot: %h", bus.m_ready);
   a_rvalid_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(bus.m_rvalid))
      else $error("m_rvalid not one-hot: %h", bus.m_rvalid);
   a_busy_state: assert property (@(posedge clk) disable iff (!rst_n) busy_q == (state_q != IDLE))
      else $error("busy disagrees with state");
endmodule

// File: doc/xbar_slave_port.md
Name: xbar_slave_port

Overview:
- Per-slave front end of the crossbar. Sits directly upstream of the 16-way round-robin arbiter and downstream of the 16 masters.
- Collects master requests targeting this slave and presents them to the arbiter. Latches the one-hot grant and the winning master's command.
- Runs one command/response transaction to the slave, then routes the response back to the owning master.
- Guarantees that the arbiter sees a request only when the port is free, so the round-robin pointer advances exactly once per transaction.

Parameters:
- AW, 32, address width
- DW, 64, data width
- Master count fixed at 16, matching the arbiter.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- m_valid  in  16  per-master command valid for this slave
- m_wr  in  16  per-master write flag (1 = write, 0 = read)
- m_addr  in  16*AW  per-master address, master i at [i*AW +: AW]
- m_wdata  in  16*DW  per-master write data, master i at [i*DW +: DW]
- m_ready  out  16  one-hot command-accepted pulse
- m_rvalid  out  16  one-hot response-valid pulse
- m_rdata  out  DW  response data, broadcast to all masters
- arb_request  out  16  request vector to arbiter
- arb_grant  in  16  one-hot grant from arbiter (combinational from arb_request)
- s_valid  out  1  command valid to slave
- s_ready  in  1  slave accepts command
- s_wr  out  1  registered write flag
- s_addr  out  AW  registered address
- s_wdata  out  DW  registered write data
- s_rvalid  in  1  slave response/ack (reads and writes)
- s_rdata  in  DW  slave read data
- busy  out  1  port owned (state != IDLE)

Behaviour:
- States: IDLE, CMD, RESP. All state changes on posedge clk.
- Reset (async, rst_n=0):
  - state=IDLE, owner=0.
  - s_valid=0, s_wr=0, s_addr=0, s_wdata=0.
  - m_ready=0, m_rvalid=0, m_rdata=0, busy=0.
- arb_request = m_valid in IDLE, 16'b0 in CMD and RESP. The arbiter therefore never advances its mask mid-transaction.
- IDLE:
  - If arb_grant != 0: owner <= arb_grant. Capture s_wr/s_addr/s_wdata from the granted master's slice (one-hot mux, OR-reduction). m_ready = arb_grant, combinational in this same cycle. Next state CMD.
  - If arb_grant == 0: stay in IDLE. Masters must hold m_valid and payload stable until their m_ready bit is seen.
- CMD:
  - s_valid=1 with the registered payload.
  - On s_valid & s_ready: next state RESP, s_valid drops to 0 next cycle.
  - s_rvalid is ignored in CMD.
  - s_ready low holds CMD indefinitely with payload stable.
- RESP:
  - On s_rvalid: m_rvalid = owner and m_rdata = s_rdata, both combinational in this cycle. m_rdata is 0 when m_rvalid=0. Next state IDLE, owner cleared.
  - Writes also complete via s_rvalid; s_rdata is don't-care for writes.
- Latency:
  - Grant cycle T: IDLE, m_ready pulse.
  - s_valid first high at T+1.
  - Minimum transaction is 3 cycles (IDLE -> CMD -> RESP), with s_ready=1 at T+1 and s_rvalid=1 at T+2.
  - A new grant is possible at T+3, giving one mandatory IDLE cycle per transaction.
- Ordering:
  - At most one outstanding transaction.
  - m_valid changes while busy have no effect.
  - A master that got m_ready may re-assert m_valid immediately; it competes at the next IDLE.
- Non-one-hot arb_grant is a protocol violation; a simulation assertion must flag it.
- Assertions:
  - m_ready and m_rvalid are each $onehot0.
  - busy == (state != IDLE).
- Reset mid-transaction aborts it silently: no m_rvalid, and the slave sees s_valid drop asynchronously.

Test Plan:
- Single read: m_valid=16'h0004, m_addr[2]=32'h1000, m_wr=0; s_ready=1 at once; s_rvalid at the next cycle with s_rdata=64'hDEAD_BEEF -> m_ready=16'h0004 at T, s_valid at T+1 with s_addr=32'h1000, m_rvalid=16'h0004 and m_rdata=64'hDEAD_BEEF at T+2, busy=0 at T+3.
- Round-robin fairness: m_valid=16'hFFFF held, each master reasserting after its m_ready, slave zero-wait -> m_ready sequence 16'h0002, 16'h0004, ..., 16'h8000, 16'h0001, one grant every 3 cycles.
- Slave backpressure: write from master 7 with s_ready low for 5 cycles -> s_valid held 6 cycles, s_addr/s_wdata constant, arb_request=0 throughout, m_rvalid=16'h0080 after s_rvalid.
- Requests while busy: master 3 owns the port; master 9 raises m_valid during CMD -> no m_ready to master 9 until the cycle after master 3's m_rvalid, then m_ready=16'h0200.
- Spurious responses: s_rvalid=1 during IDLE and during CMD -> m_rvalid stays 0, state unchanged by it.
- Reset mid-operation: assert rst_n=0 in RESP -> all outputs 0 immediately, state IDLE; after release, master 0 request is granted with m_ready=16'h0001 since the arbiter mask also reset.
